// File: rtl/wb_rom_loader_if.sv
// Wishbone classic bus bundle between wb_rom_loader (master) and a ROM responder (slave).
// Signal names keep the initiator-side wbm_* naming of the loader's bus pins.
interface wb_rom_loader_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_rom_loader.sv
// wb_rom_loader: packs a byte stream little-endian into 32-bit words and writes
// them over Wishbone classic to sequential word addresses of the ROM SRAM.
// Optional feature: define WB_ROM_LOADER_VERIFY_EN to read back every written
// word and abort with err_o on the first mismatch.
module wb_rom_loader #(
    parameter int CNT_W       = 10,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 start_i,
    input  logic [31:0]          base_adr_i,
    input  logic [CNT_W-1:0]     word_cnt_i,
    input  logic [7:0]           s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    wb_rom_loader_if.master      wbm,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          err_adr_o
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
`ifdef WB_ROM_LOADER_VERIFY_EN
    localparam logic [2:0] S_RDBK  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
`endif
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] remain;
    logic [1:0]       byte_cnt;
    logic [31:0]      pack;
    logic [31:0]      word_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             byte_hs;
    logic             ack_seen;
    logic             tmo_hit;
    logic             unused_sink;
`ifdef WB_ROM_LOADER_VERIFY_EN
    logic [31:0]      rd_data;
`endif

    // Byte lanes are fixed: every access is a full word.
    assign wbm.wbm_sel_o = 4'hF;

    // New bytes enter at the top so after four shifts the first byte sits in [7:0].
    assign byte_hs  = s_valid_i & s_ready_o;
    assign word_nxt = {s_data_i, pack[31:8]};

    // An ack only counts while a cycle is open; a stray ack on an idle bus is ignored.
    assign ack_seen = wbm.wbm_cyc_o & wbm.wbm_ack_i;
    assign tmo_hit  = wbm.wbm_cyc_o & ~wbm.wbm_ack_i &
                      (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

    // Word-alignment bits of the base (and read data when not verifying) are don't-care.
`ifdef WB_ROM_LOADER_VERIFY_EN
    assign unused_sink = ^base_adr_i[1:0];
`else
    assign unused_sink = ^{base_adr_i[1:0], wbm.wbm_dat_i};
`endif

    // Wait-state counter: cyc is always low just before WRITE/RDBK issue, so
    // clearing on cyc=0 restarts it at the start of every access.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n)
            tmo_cnt <= '0;
        else if (wbm.wbm_cyc_o && !wbm.wbm_ack_i)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        else
            tmo_cnt <= '0;
    end

    // Byte packer: shifts accepted bytes; stale bits are fully shifted out per word.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n)
            pack <= '0;
        else if (byte_hs)
            pack <= word_nxt;
    end

    // Job sequencer and Wishbone master: all bus outputs are registered.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state         <= S_IDLE;
            remain        <= '0;
            byte_cnt      <= '0;
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_adr_o <= '0;
            wbm.wbm_dat_o <= '0;
            s_ready_o     <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            err_adr_o     <= '0;
`ifdef WB_ROM_LOADER_VERIFY_EN
            rd_data       <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        wbm.wbm_adr_o <= {base_adr_i[31:2], 2'b00};
                        remain        <= word_cnt_i;
                        byte_cnt      <= '0;
                        err_o         <= 1'b0;
                        err_adr_o     <= '0;
                        busy_o        <= 1'b1;
                        if (word_cnt_i == '0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_FILL;
                            s_ready_o <= 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (byte_hs) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wbm.wbm_dat_o <= word_nxt;
                            wbm.wbm_cyc_o <= 1'b1;
                            wbm.wbm_stb_o <= 1'b1;
                            wbm.wbm_we_o  <= 1'b1;
                            s_ready_o     <= 1'b0;
                            state         <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (ack_seen) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
`ifdef WB_ROM_LOADER_VERIFY_EN
                        state         <= S_RDBK;
`else
                        state         <= S_NEXT;
`endif
                    end else if (tmo_hit) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        err_o         <= 1'b1;
                        err_adr_o     <= wbm.wbm_adr_o;
                        state         <= S_DONE;
                    end
                end

`ifdef WB_ROM_LOADER_VERIFY_EN
                // One idle cycle after the write ack, then a fresh read cycle.
                S_RDBK: begin
                    if (!wbm.wbm_cyc_o) begin
                        wbm.wbm_cyc_o <= 1'b1;
                        wbm.wbm_stb_o <= 1'b1;
                        wbm.wbm_we_o  <= 1'b0;
                    end else if (ack_seen) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        rd_data       <= wbm.wbm_dat_i;
                        state         <= S_CHECK;
                    end else if (tmo_hit) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        err_o         <= 1'b1;
                        err_adr_o     <= wbm.wbm_adr_o;
                        state         <= S_DONE;
                    end
                end

                S_CHECK: begin
                    if (rd_data != wbm.wbm_dat_o) begin
                        err_o     <= 1'b1;
                        err_adr_o <= wbm.wbm_adr_o;
                        state     <= S_DONE;
                    end else begin
                        state     <= S_NEXT;
                    end
                end
`endif

                S_NEXT: begin
                    wbm.wbm_adr_o <= wbm.wbm_adr_o + 32'd4;
                    remain        <= remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        state <= S_DONE;
                    end else begin
                        state     <= S_FILL;
                        s_ready_o <= 1'b1;
                        byte_cnt  <= '0;
                    end
                end

                S_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rom_loader.sv
// Directed bench for wb_rom_loader: zero/multi-wait responder with a small word
// memory, scoreboard of expected writes, timeout, cnt=0, reset mid-write, and
// (with WB_ROM_LOADER_VERIFY_EN) readback corruption.
module tb_wb_rom_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_adr = '0;
    logic [9:0]  word_cnt = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        busy, done, err;
    logic [31:0] err_adr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_rom_loader_if bus();

    wb_rom_loader #(.CNT_W(10), .ACK_TIMEOUT(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .start_i    (start),
        .base_adr_i (base_adr),
        .word_cnt_i (word_cnt),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .wbm        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_adr_o  (err_adr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Responder configuration driven by the stimulus.
    int          waits = 0;
    logic        hold_ack = 1'b0;
    logic [31:0] no_ack_adr = 32'hFFFF_FFFF;
    logic [31:0] bad_adr = 32'hFFFF_FFFF;
    int          wcnt = 0;
    logic [31:0] mem [64];
    logic [31:0] rdv;

    assign bus.wbm_ack_i = bus.wbm_cyc_o && bus.wbm_stb_o && !hold_ack &&
                           (bus.wbm_adr_o != no_ack_adr) && (wcnt >= waits);

    always_comb begin
        rdv = mem[bus.wbm_adr_o[7:2]];
        if (bus.wbm_adr_o == bad_adr) rdv[0] = ~rdv[0];
    end
    assign bus.wbm_dat_i = rdv;

    // Observed bus activity and monitors.
    logic [31:0] wr_adr_q[$], wr_dat_q[$], rd_adr_q[$];
    logic [31:0] exp_adr_q[$], exp_dat_q[$];
    logic [7:0]  tx_q[$];
    int cyc_cycles = 0, ready_cycles = 0, unstable = 0;
    logic        prev_cyc = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_adr = '0, prev_dat = '0;

    always @(posedge clk) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.wbm_ack_i && bus.wbm_we_o) begin
            mem[bus.wbm_adr_o[7:2]] <= bus.wbm_dat_o;
            wr_adr_q.push_back(bus.wbm_adr_o);
            wr_dat_q.push_back(bus.wbm_dat_o);
        end
        if (bus.wbm_ack_i && !bus.wbm_we_o) rd_adr_q.push_back(bus.wbm_adr_o);
        if (bus.wbm_cyc_o) cyc_cycles <= cyc_cycles + 1;
        if (s_ready) ready_cycles <= ready_cycles + 1;
        if (bus.wbm_cyc_o && prev_cyc && !prev_ack &&
            (bus.wbm_adr_o != prev_adr || bus.wbm_dat_o != prev_dat || bus.wbm_we_o != prev_we))
            unstable <= unstable + 1;
        prev_cyc <= bus.wbm_cyc_o;
        prev_ack <= bus.wbm_ack_i;
        prev_we  <= bus.wbm_we_o;
        prev_adr <= bus.wbm_adr_o;
        prev_dat <= bus.wbm_dat_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] b, input logic [9:0] c);
        base_adr = b;
        word_cnt = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Queue the four bytes of a word; optionally record the expected write.
    task automatic push_word(input logic [31:0] adr, input logic [7:0] b0, b1, b2, b3,
                             input bit expect_wr);
        tx_q.push_back(b0); tx_q.push_back(b1); tx_q.push_back(b2); tx_q.push_back(b3);
        if (expect_wr) begin
            exp_adr_q.push_back(adr);
            exp_dat_q.push_back({b3, b2, b1, b0});
        end
    endtask

    task automatic send_stream(input bit toggle);
        int  guard = 0;
        bit  hs;
        while (tx_q.size() > 0 && guard < 2000) begin
            s_data  = tx_q[0];
            s_valid = !(toggle && guard[0]);
            hs      = s_valid && s_ready;
            tick();
            if (hs) void'(tx_q.pop_front());
            guard++;
        end
        s_valid = 1'b0;
        chk("stream_drained", tx_q.size(), 0);
        tx_q.delete();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 500) begin
            tick();
            n++;
        end
        chk($sformatf("%s_done", tag), done, 1'b1);
        tick();
        chk($sformatf("%s_done_pulse", tag), {done, busy}, 2'b00);
    endtask

    task automatic check_writes(input string tag);
        chk($sformatf("%s_nwrites", tag), wr_adr_q.size(), exp_adr_q.size());
        while (exp_adr_q.size() > 0 && wr_adr_q.size() > 0) begin
            chk($sformatf("%s_adr", tag), wr_adr_q.pop_front(), exp_adr_q.pop_front());
            chk($sformatf("%s_dat", tag), wr_dat_q.pop_front(), exp_dat_q.pop_front());
        end
        exp_adr_q.delete(); exp_dat_q.delete();
        wr_adr_q.delete();  wr_dat_q.delete();
        rd_adr_q.delete();
    endtask

    initial begin
        int c0, r0, u0;

        // Reset state
        tick(); tick();
        chk("rst_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, s_ready, busy, done, err}, 7'b0);
        chk("rst_sel", bus.wbm_sel_o, 4'hF);
        chk("rst_adr", bus.wbm_adr_o, 32'h0);
        chk("rst_dat", bus.wbm_dat_o, 32'h0);
        chk("rst_err_adr", err_adr, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: two words, zero-wait responder
        waits = 0;
        start_job(32'h3000_0003, 10'd2);
        chk("t1_busy", busy, 1'b1);
        push_word(32'h3000_0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        push_word(32'h3000_0004, 8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
        send_stream(1'b0);
        wait_done("t1");
        chk("t1_err", err, 1'b0);
        check_writes("t1");

        // 2: three wait states, gappy stream, ignored start while busy
        waits = 3;
        u0 = unstable;
        start_job(32'h3000_0000, 10'd2);
        word_cnt = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_word(32'h3000_0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        push_word(32'h3000_0004, 8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
        send_stream(1'b1);
        wait_done("t2");
        chk("t2_stable", unstable - u0, 0);
        chk("t2_err", err, 1'b0);
        check_writes("t2");

        // 4: second word never acked -> timeout after 8 cycles
        waits = 0;
        no_ack_adr = 32'h0000_0104;
        c0 = cyc_cycles;
        start_job(32'h0000_0100, 10'd3);
        push_word(32'h0000_0100, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
        push_word(32'h0000_0104, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b0);
        send_stream(1'b0);
        wait_done("t4");
`ifdef WB_ROM_LOADER_VERIFY_EN
        chk("t4_cyc_cycles", cyc_cycles - c0, 10);
`else
        chk("t4_cyc_cycles", cyc_cycles - c0, 9);
`endif
        chk("t4_err", err, 1'b1);
        chk("t4_err_adr", err_adr, 32'h0000_0104);
        chk("t4_bus_idle", bus.wbm_cyc_o, 1'b0);
        check_writes("t4");
        no_ack_adr = 32'hFFFF_FFFF;

`ifdef WB_ROM_LOADER_VERIFY_EN
        // 5: readback of 0x108 corrupted -> abort before 0x10C
        bad_adr = 32'h0000_0108;
        start_job(32'h0000_0100, 10'd4);
        push_word(32'h0000_0100, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        push_word(32'h0000_0104, 8'h05, 8'h06, 8'h07, 8'h08, 1'b1);
        push_word(32'h0000_0108, 8'h09, 8'h0A, 8'h0B, 8'h0C, 1'b1);
        send_stream(1'b0);
        wait_done("t5");
        chk("t5_err", err, 1'b1);
        chk("t5_err_adr", err_adr, 32'h0000_0108);
        chk("t5_nreads", rd_adr_q.size(), 3);
        chk("t5_last_read", rd_adr_q[$], 32'h0000_0108);
        check_writes("t5");
        bad_adr = 32'hFFFF_FFFF;
`endif

        // 3: cnt=0 -> done two cycles after start, no bus, no s_ready; clears err
        c0 = cyc_cycles;
        r0 = ready_cycles;
        start_job(32'h0000_0200, 10'd0);
        chk("t3_err_clr", err, 1'b0);
        chk("t3_err_adr_clr", err_adr, 32'h0);
        chk("t3_not_yet", done, 1'b0);
        tick();
        chk("t3_done", done, 1'b1);
        tick();
        chk("t3_done_pulse", done, 1'b0);
        chk("t3_no_cyc", cyc_cycles - c0, 0);
        chk("t3_no_ready", ready_cycles - r0, 0);

        // 6: reset during a stalled write, then a fresh one-word job
        hold_ack = 1'b1;
        start_job(32'h0000_0200, 10'd2);
        push_word(32'h0000_0200, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0);
        send_stream(1'b0);
        chk("t6_in_write", bus.wbm_cyc_o, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, busy, s_ready}, 4'b0);
        rst_n = 1'b1;
        hold_ack = 1'b0;
        tick();
        start_job(32'h0000_0200, 10'd1);
        push_word(32'h0000_0200, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b1);
        send_stream(1'b0);
        wait_done("t6");
        chk("t6_err", err, 1'b0);
        check_writes("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
